// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed at launch and committed after a fixed busy period.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]        res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic               skip_q, skip_d;

    // Arithmetic datapath on the launch-edge operands
    logic        is_signed;
    logic [63:0] ext_a, ext_b, prod;
    logic        a_neg, b_neg;
    logic [31:0] abs_a, abs_b, div_b, q_u, r_u, quot, rem;
    logic [31:0] calc_hi, calc_lo;

    always_comb begin
        is_signed = ~op[0];
        ext_a     = {{32{a[31] & is_signed}}, a};
        ext_b     = {{32{b[31] & is_signed}}, b};
        prod      = ext_a * ext_b;

        // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0
        a_neg = is_signed & a[31];
        b_neg = is_signed & b[31];
        abs_a = a_neg ? (~a + 32'd1) : a;
        abs_b = b_neg ? (~b + 32'd1) : b;
        div_b = (b == 32'd0) ? 32'd1 : abs_b;
        q_u   = abs_a / div_b;
        r_u   = abs_a % div_b;
        quot  = (a_neg ^ b_neg) ? (~q_u + 32'd1) : q_u;
        rem   = a_neg ? (~r_u + 32'd1) : r_u;

        calc_hi = op[1] ? rem  : prod[63:32];
        calc_lo = op[1] ? quot : prod[31:0];
    end

    // State and architectural registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            skip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            skip_q   <= skip_d;
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        skip_d   = skip_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    cnt_d    = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    res_hi_d = calc_hi;
                    res_lo_d = calc_lo;
                    skip_d   = op[1] & (b == 32'd0);
                end else begin
                    if (mthi) hi_d = a;
                    if (mtlo) lo_d = a;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    // Divide by zero leaves HI/LO untouched
                    if (!skip_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end
            end
        endcase
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus queues expected HI/LO and busy length,
// a negedge monitor checks on each busy fall and on each probe request.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;
    logic        probe = 1'b0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_probe;
        logic        exp_busy;
        int          busy_len;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    total = 0;
    int    passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h required %h", nm, act, expv);
    endtask

    task automatic fail_evt(input string nm);
        total++;
        $display("FAIL %s", nm);
    endtask

    // Monitor
    int   busy_len = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t  e;
        string n;
        if (busy === 1'b1) busy_len++;
        else if (prev_busy) begin
            if (sb_q.size() == 0) fail_evt("unexpected busy period");
            else begin
                e = sb_q.pop_front();
                n = nm_q.pop_front();
                if (e.is_probe) fail_evt({n, " expected probe, saw completion"});
                chk({n, " busy_len"}, 32'(busy_len), 32'(e.busy_len));
                chk({n, " hi"}, hi, e.exp_hi);
                chk({n, " lo"}, lo, e.exp_lo);
            end
            busy_len = 0;
        end
        if (probe) begin
            if (sb_q.size() == 0) fail_evt("probe with empty scoreboard");
            else begin
                e = sb_q.pop_front();
                n = nm_q.pop_front();
                if (!e.is_probe) fail_evt({n, " expected completion, saw probe"});
                chk({n, " busy"}, 32'(busy), 32'(e.exp_busy));
                chk({n, " hi"}, hi, e.exp_hi);
                chk({n, " lo"}, lo, e.exp_lo);
            end
        end
        prev_busy = busy;
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_done(input string n, input int len, input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e = '{is_probe: 1'b0, exp_busy: 1'b0, busy_len: len, exp_hi: h, exp_lo: l};
        sb_q.push_back(e);
        nm_q.push_back(n);
    endtask

    // Push a probe expectation and raise probe for the current cycle
    task automatic do_probe(input string n, input logic bz, input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e = '{is_probe: 1'b1, exp_busy: bz, busy_len: 0, exp_hi: h, exp_lo: l};
        sb_q.push_back(e);
        nm_q.push_back(n);
        probe = 1'b1;
        cyc();
        probe = 1'b0;
    endtask

    task automatic drain(input string n);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 40) begin
            cyc();
            k++;
        end
        if (sb_q.size() != 0) begin
            fail_evt({n, " timeout waiting for completion"});
            sb_q.delete();
            nm_q.delete();
        end
    endtask

    task automatic launch(input string n, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int len, input logic [31:0] h, input logic [31:0] l);
        push_done(n, len, h, l);
        start = 1'b1; op = o; a = x; b = y;
        cyc();
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF;
        drain(n);
        cyc();
    endtask

    initial begin
        cyc(2);
        reset = 1'b0;
        do_probe("reset", 1'b0, 32'h0, 32'h0);

        launch("mult -2*3",   2'b00, 32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
        launch("multu max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001);
        launch("div -7/2",    2'b10, 32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        launch("divu 7/0",    2'b11, 32'd7,         32'd0,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // MTHI then MTLO, each visible one cycle later with busy low
        mthi = 1'b1; a = 32'h1234_5678; cyc(); mthi = 1'b0;
        do_probe("mthi", 1'b0, 32'h1234_5678, 32'hFFFF_FFFD);
        mtlo = 1'b1; a = 32'h9ABC_DEF0; cyc(); mtlo = 1'b0;
        do_probe("mtlo", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);

        // start wins over mthi: hi keeps old value during RUN, then gets the product
        push_done("start+mthi", 5, 32'h0, 32'd6);
        start = 1'b1; mthi = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
        cyc();
        start = 1'b0; mthi = 1'b0;
        sb_q.push_front('{is_probe: 1'b1, exp_busy: 1'b1, busy_len: 0, exp_hi: 32'h1234_5678, exp_lo: 32'h9ABC_DEF0});
        nm_q.push_front("start+mthi in run");
        probe = 1'b1; cyc(); probe = 1'b0;
        drain("start+mthi"); cyc();

        // start and mtlo during RUN are ignored
        push_done("mult 4*5 ignore", 5, 32'h0, 32'd20);
        start = 1'b1; op = 2'b00; a = 32'd4; b = 32'd5;
        cyc();
        start = 1'b0;
        cyc();
        start = 1'b1; mtlo = 1'b1; op = 2'b10; a = 32'd99; b = 32'd1;
        cyc();
        start = 1'b0; mtlo = 1'b0;
        drain("mult 4*5 ignore");
        cyc(15);

        launch("div ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0,         32'h8000_0000);
        launch("div 7/-2",    2'b10, 32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        launch("divu big",    2'b11, 32'hFFFF_FFFF, 32'h10,        10, 32'h0000_000F, 32'h0FFF_FFFF);

        // Reset in cycle 4 of a DIV, then MULTU 3*3 launched in cycle 5
        push_done("reset in run", 4, 32'h0, 32'h0);
        push_done("multu 3*3", 5, 32'h0, 32'd9);
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        cyc();
        start = 1'b0;
        cyc(3);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
        cyc();
        start = 1'b0;
        drain("multu 3*3");
        cyc(15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
